// File: rtl/sync_serial_multiplier.sv
// Bit-serial operand loader feeding a sequential shift-add multiplier.
// Two WIDTH-bit unsigned operands arrive one bit per accepted cycle on
// data_in (A first, then B). WIDTH shift-add steps then build the
// 2*WIDTH-bit product, which is held on multiply until the consumer takes it.
//
// Handshakes: a beat moves on a rising edge where valid and ready are both
// high. Input side: accept = in_valid & in_ready, and in_ready is high only
// while loading. Output side: the product is taken on an edge with
// out_valid & out_ready; out_valid stays high, and multiply stays stable,
// until that edge.
module sync_serial_multiplier #(
   parameter int WIDTH     = 4,
   parameter bit LSB_FIRST = 1'b1
) (
   input  logic                 fast_clk,
   input  logic                 reset,
   input  logic                 data_in,
   input  logic                 in_valid,
   output logic                 in_ready,
   output logic [2*WIDTH-1:0]   multiply,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic                 busy,
   output logic [1:0]           state_dbg
);

   // Count only has to reach WIDTH-1: loading and multiplying both wrap to 0
   // on their last step.
   localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      LOAD_A = 2'd0,
      LOAD_B = 2'd1,
      MULT   = 2'd2,
      DONE   = 2'd3
   } state_t;

   state_t               state_q, state_d;
   logic [CW-1:0]        count_q, count_d;
   logic [WIDTH-1:0]     a_q, a_d;
   logic [WIDTH-1:0]     b_q, b_d;
   logic [2*WIDTH-1:0]   acc_q, acc_d;
   logic [2*WIDTH-1:0]   mult_q, mult_d;
   logic                 accept;

   // LSB-first streams fill from the top and shift down, so the first bit ends
   // up in bit 0; MSB-first streams fill from the bottom and shift up.
   function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] r,
                                                  input logic             b);
      if (LSB_FIRST) return {b, r[WIDTH-1:1]};
      else           return {r[WIDTH-2:0], b};
   endfunction

   // Handshake and status outputs decode straight from the registered state.
   always_comb begin
      in_ready  = (state_q == LOAD_A) || (state_q == LOAD_B);
      out_valid = (state_q == DONE);
      busy      = !((state_q == LOAD_A) && (count_q == '0));
      multiply  = mult_q;
      state_dbg = state_q;
      accept    = in_valid && in_ready;
   end

   // Next-state logic: serial loading, one shift-add step per MULT cycle,
   // and holding the product in DONE until the consumer is ready.
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      a_d     = a_q;
      b_d     = b_q;
      acc_d   = acc_q;
      mult_d  = mult_q;
      case (state_q)
         LOAD_A: begin
            if (accept) begin
               a_d = shift_in(a_q, data_in);
               if (count_q == LAST) begin
                  count_d = '0;
                  state_d = LOAD_B;
               end else begin
                  count_d = count_q + 1'b1;
               end
            end
         end
         LOAD_B: begin
            if (accept) begin
               b_d = shift_in(b_q, data_in);
               if (count_q == LAST) begin
                  count_d = '0;
                  acc_d   = '0;
                  state_d = MULT;
               end else begin
                  count_d = count_q + 1'b1;
               end
            end
         end
         MULT: begin
            // A partial product A<<i is at most 2*WIDTH-1 bits wide and the
            // sum of all of them fits in 2*WIDTH bits, so no carry is lost.
            if (b_q[count_q]) begin
               acc_d = acc_q + ({{WIDTH{1'b0}}, a_q} << count_q);
            end
            if (count_q == LAST) begin
               mult_d  = acc_d;
               count_d = '0;
               state_d = DONE;
            end else begin
               count_d = count_q + 1'b1;
            end
         end
         DONE: begin
            if (out_ready) begin
               count_d = '0;
               state_d = LOAD_A;
            end
         end
         default: begin
            count_d = '0;
            state_d = LOAD_A;
         end
      endcase
   end

   // State registers; reset discards partial operands and any pending product.
   always_ff @(posedge fast_clk) begin
      if (reset) begin
         state_q <= LOAD_A;
         count_q <= '0;
         a_q     <= '0;
         b_q     <= '0;
         acc_q   <= '0;
         mult_q  <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         a_q     <= a_d;
         b_q     <= b_d;
         acc_q   <= acc_d;
         mult_q  <= mult_d;
      end
   end

endmodule

// File: tb/tb_sync_serial_multiplier.sv
// Directed bench for sync_serial_multiplier: a WIDTH=4 LSB-first instance
// for most scenarios and a WIDTH=8 MSB-first instance for the parameter test.
module tb_sync_serial_multiplier;

   // ---------------- clock / reset ----------------
   logic fast_clk;
   logic reset;

   initial begin
      fast_clk = 1'b0;
      forever #5 fast_clk = ~fast_clk;
   end

   int cyc;
   always @(posedge fast_clk) cyc <= cyc + 1;

   // ---------------- WIDTH=4, LSB-first DUT ----------------
   logic       data_in, in_valid, in_ready, out_valid, out_ready, busy;
   logic [7:0] multiply;
   logic [1:0] state_dbg;

   sync_serial_multiplier #(.WIDTH(4), .LSB_FIRST(1'b1)) dut (
      .fast_clk  (fast_clk),
      .reset     (reset),
      .data_in   (data_in),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .multiply  (multiply),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .busy      (busy),
      .state_dbg (state_dbg)
   );

   // ---------------- WIDTH=8, MSB-first DUT ----------------
   logic        d8_data, d8_valid, d8_in_ready, d8_out_valid, d8_out_ready, d8_busy;
   logic [15:0] d8_multiply;
   logic [1:0]  d8_state;

   sync_serial_multiplier #(.WIDTH(8), .LSB_FIRST(1'b0)) dut8 (
      .fast_clk  (fast_clk),
      .reset     (reset),
      .data_in   (d8_data),
      .in_valid  (d8_valid),
      .in_ready  (d8_in_ready),
      .multiply  (d8_multiply),
      .out_valid (d8_out_valid),
      .out_ready (d8_out_ready),
      .busy      (d8_busy),
      .state_dbg (d8_state)
   );

   // ---------------- scoreboard ----------------
   logic [7:0] exp_q[$];
   logic [7:0] exp_v;
   int         n_cmp;
   int         n_bad;

   // ---------------- driver tasks ----------------
   // Present one bit and hold it until the DUT accepts it on an edge.
   task automatic send_bit(input logic b);
      data_in  = b;
      in_valid = 1'b1;
      for (int i = 0; i < 40; i++) begin
         if (in_ready) begin
            @(posedge fast_clk); #1;
            in_valid = 1'b0;
            data_in  = 1'b0;
            return;
         end
         @(posedge fast_clk); #1;
      end
      n_cmp++; n_bad++;
      $display("FAIL send_bit: in_ready=%b after 40 cycles, required 1", in_ready);
      in_valid = 1'b0;
   endtask

   task automatic send_op4(input logic [3:0] v);
      for (int i = 0; i < 4; i++) send_bit(v[i]);
   endtask

   // Count edges until out_valid is seen high (sampled 1 time unit after each edge).
   task automatic wait_valid(input int max_edges, output int edges, output logic ok);
      edges = 0;
      ok    = 1'b0;
      while (edges < max_edges) begin
         @(posedge fast_clk); #1;
         edges++;
         if (out_valid) begin
            ok = 1'b1;
            return;
         end
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      reset = 1'b1; in_valid = 1'b0; data_in = 1'b0; out_ready = 1'b0;
      d8_valid = 1'b0; d8_data = 1'b0; d8_out_ready = 1'b0;
      repeat (2) @(posedge fast_clk);
      #1;
      n_cmp++; if (multiply !== 8'h00) begin n_bad++; $display("FAIL reset_multiply: got %h want 00", multiply); end
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
      n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
      n_cmp++; if (d8_multiply !== 16'h0000) begin n_bad++; $display("FAIL reset_multiply8: got %h want 0000", d8_multiply); end
      reset = 1'b0;
   endtask

   task automatic test_basic();
      int   e;
      logic ok;
      out_ready = 1'b1;
      exp_q.push_back(8'h1E);
      send_op4(4'b1010);
      send_op4(4'b0011);
      wait_valid(20, e, ok);
      n_cmp++; if (!ok || e != 4) begin n_bad++; $display("FAIL basic_latency: out_valid after %0d edges (seen=%b), want 4", e, ok); end
      exp_v = exp_q.pop_front();
      n_cmp++; if (multiply !== exp_v) begin n_bad++; $display("FAIL basic_product: got %h want %h", multiply, exp_v); end
      @(posedge fast_clk); #1;
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL basic_pulse: out_valid got %b want 0", out_valid); end
      n_cmp++; if (state_dbg !== 2'd0 || busy !== 1'b0) begin n_bad++; $display("FAIL basic_idle: state %0d busy %b want 0/0", state_dbg, busy); end
      n_cmp++; if (multiply !== 8'h1E) begin n_bad++; $display("FAIL basic_hold: got %h want 1e", multiply); end
   endtask

   task automatic test_back_to_back();
      logic [3:0] a_tab[3];
      logic [3:0] b_tab[3];
      logic [7:0] p_tab[3];
      int         done_cyc[3];
      int         e;
      logic       ok;
      a_tab = '{4'd15, 4'd0,  4'd1};
      b_tab = '{4'd15, 4'd13, 4'd9};
      p_tab = '{8'hE1, 8'h00, 8'h09};
      out_ready = 1'b1;
      for (int k = 0; k < 3; k++) exp_q.push_back(p_tab[k]);
      for (int k = 0; k < 3; k++) begin
         send_op4(a_tab[k]);
         send_op4(b_tab[k]);
         wait_valid(20, e, ok);
         done_cyc[k] = cyc;
         n_cmp++; if (!ok || e != 4) begin n_bad++; $display("FAIL b2b_latency[%0d]: %0d edges (seen=%b), want 4", k, e, ok); end
         exp_v = exp_q.pop_front();
         n_cmp++; if (multiply !== exp_v) begin n_bad++; $display("FAIL b2b_product[%0d]: got %h want %h", k, multiply, exp_v); end
         if (k > 0) begin
            n_cmp++;
            if (done_cyc[k] - done_cyc[k-1] != 13) begin
               n_bad++; $display("FAIL b2b_throughput[%0d]: %0d cycles want 13", k, done_cyc[k] - done_cyc[k-1]);
            end
         end
      end
      @(posedge fast_clk); #1;
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_once: out_valid got %b want 0", out_valid); end
   endtask

   task automatic test_stall();
      int   e, t0;
      logic ok;
      logic [3:0] a;
      a = 4'd6;
      out_ready = 1'b0;
      exp_q.push_back(8'h2A);
      send_bit(a[0]);
      t0 = cyc;
      send_bit(a[1]);
      repeat (3) begin
         @(posedge fast_clk); #1;
         n_cmp++;
         if (state_dbg !== 2'd0 || busy !== 1'b1 || in_ready !== 1'b1) begin
            n_bad++; $display("FAIL stall_hold: state %0d busy %b in_ready %b want 0/1/1", state_dbg, busy, in_ready);
         end
      end
      send_bit(a[2]);
      send_bit(a[3]);
      send_op4(4'd7);
      wait_valid(20, e, ok);
      n_cmp++; if (!ok || cyc - t0 != 14) begin n_bad++; $display("FAIL stall_delay: done %0d cycles after first bit (seen=%b), want 14", cyc - t0, ok); end
      // Drive a bit during DONE; it must be ignored.
      in_valid = 1'b1; data_in = 1'b1;
      repeat (5) begin
         @(posedge fast_clk); #1;
         n_cmp++;
         if (out_valid !== 1'b1 || multiply !== 8'h2A || in_ready !== 1'b0 || state_dbg !== 2'd3) begin
            n_bad++; $display("FAIL backpressure_hold: out_valid %b multiply %h in_ready %b state %0d want 1/2a/0/3",
                              out_valid, multiply, in_ready, state_dbg);
         end
      end
      in_valid = 1'b0; data_in = 1'b0;
      out_ready = 1'b1;
      exp_v = exp_q.pop_front();
      n_cmp++; if (multiply !== exp_v) begin n_bad++; $display("FAIL stall_product: got %h want %h", multiply, exp_v); end
      @(posedge fast_clk); #1;
      n_cmp++; if (out_valid !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL backpressure_release: out_valid %b busy %b want 0/0", out_valid, busy); end
   endtask

   task automatic test_reset_midop();
      int   e;
      logic ok;
      out_ready = 1'b1;
      send_op4(4'd7);
      send_bit(1'b1);
      send_bit(1'b0);
      n_cmp++; if (state_dbg !== 2'd1 || busy !== 1'b1) begin n_bad++; $display("FAIL midop_loading: state %0d busy %b want 1/1", state_dbg, busy); end
      reset = 1'b1;
      @(posedge fast_clk); #1;
      reset = 1'b0;
      n_cmp++;
      if (state_dbg !== 2'd0 || busy !== 1'b0 || in_ready !== 1'b1 || multiply !== 8'h00) begin
         n_bad++; $display("FAIL midop_reset: state %0d busy %b in_ready %b multiply %h want 0/0/1/00",
                           state_dbg, busy, in_ready, multiply);
      end
      exp_q.push_back(8'h0F);
      send_op4(4'd3);
      send_op4(4'd5);
      wait_valid(20, e, ok);
      n_cmp++; if (!ok || e != 4) begin n_bad++; $display("FAIL midop_latency: %0d edges (seen=%b), want 4", e, ok); end
      exp_v = exp_q.pop_front();
      n_cmp++; if (multiply !== exp_v) begin n_bad++; $display("FAIL midop_product: got %h want %h", multiply, exp_v); end
      @(posedge fast_clk); #1;
   endtask

   task automatic test_params();
      logic [7:0] a, b;
      int         e;
      a = 8'hFF;
      b = 8'h02;
      d8_out_ready = 1'b1;
      for (int i = 15; i >= 0; i--) begin
         d8_data  = (i >= 8) ? a[i-8] : b[i];
         d8_valid = 1'b1;
         n_cmp++; if (d8_in_ready !== 1'b1) begin n_bad++; $display("FAIL w8_in_ready[%0d]: got %b want 1", i, d8_in_ready); end
         @(posedge fast_clk); #1;
      end
      d8_valid = 1'b0; d8_data = 1'b0;
      e = 0;
      while (e < 20) begin
         @(posedge fast_clk); #1;
         e++;
         if (d8_out_valid) break;
      end
      n_cmp++; if (d8_out_valid !== 1'b1 || e != 8) begin n_bad++; $display("FAIL w8_latency: %0d edges valid %b, want 8/1", e, d8_out_valid); end
      n_cmp++; if (d8_multiply !== 16'h01FE) begin n_bad++; $display("FAIL w8_product: got %h want 01fe", d8_multiply); end
      @(posedge fast_clk); #1;
      n_cmp++; if (d8_out_valid !== 1'b0) begin n_bad++; $display("FAIL w8_pulse: out_valid got %b want 0", d8_out_valid); end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      cyc   = 0;
      n_cmp = 0;
      n_bad = 0;
      test_reset();
      test_basic();
      test_back_to_back();
      test_stall();
      test_reset_midop();
      test_params();
      n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL scoreboard_drain: %0d products never seen, want 0", exp_q.size()); end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
